mac_pe_dbuf: RTL and testbench

Weight-stationary systolic processing element, successor to the single-lane MAC PE in the systolic array. It adds:
- LANES parallel activation/partial-sum channels sharing one stationary weight.
- A double-buffered weight register, so the next weight loads while the current one computes.
- Optional saturating accumulation, plus sticky overflow and zero-skip statistics.

It tiles the array exactly as the previous PE did: activations flow horizontally, weights and partial sums flow vertically.

---
 rtl/mac_pe_dbuf.sv | 256 +++++++++++++++++++++++++
 tb/tb_mac_pe_dbuf.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_dbuf.sv
// mac_pe_dbuf: weight-stationary systolic processing element with LANES
// activation/partial-sum channels sharing one double-buffered weight.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   w_swap_in/out            weight swap pulse, registered pass-through
//   w_data_in/out            weight stream, registered pass-through
//   w_valid_in/out           weight stream valid, registered pass-through
//   a_data_in/out            activations (lane 0 in LSBs), registered pass-through
//   a_valid_in/out           activation valid, registered pass-through
//   p_data_in, p_valid_in    partial sums from the row above (1 cycle after a_data_in)
//   p_data_out, p_valid_out  partial sums to the row below (2 cycles after a_data_in)
//   clr_stat_in              synchronous clear of sat_flag and skip_cnt
//   sat_flag                 sticky: some lane overflowed (clamped or wrapped)
//   skip_cnt                 saturating count of lane-MACs skipped on a zero operand
module mac_pe_dbuf #(
  parameter int A_BITWIDTH    = 16,
  parameter int W_BITWIDTH    = 8,
  parameter int P_BITWIDTH    = 40,
  parameter int LANES         = 2,
  parameter int ROW_NUM       = 27,
  parameter int ROW_INDEX     = 0,
  parameter int SATURATE      = 1,
  parameter int STAT_BITWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_swap_in,
  output logic                          w_swap_out,
  input  logic [W_BITWIDTH-1:0]         w_data_in,
  output logic [W_BITWIDTH-1:0]         w_data_out,
  input  logic                          w_valid_in,
  output logic                          w_valid_out,
  input  logic [LANES*A_BITWIDTH-1:0]   a_data_in,
  output logic [LANES*A_BITWIDTH-1:0]   a_data_out,
  input  logic                          a_valid_in,
  output logic                          a_valid_out,
  input  logic [LANES*P_BITWIDTH-1:0]   p_data_in,
  input  logic                          p_valid_in,
  output logic [LANES*P_BITWIDTH-1:0]   p_data_out,
  output logic                          p_valid_out,
  input  logic                          clr_stat_in,
  output logic                          sat_flag,
  output logic [STAT_BITWIDTH-1:0]      skip_cnt
);

  localparam int M_BITWIDTH     = A_BITWIDTH + W_BITWIDTH;
  localparam int CNT_BITWIDTH   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int NSKIP_BITWIDTH = $clog2(LANES + 1);
  localparam logic [CNT_BITWIDTH-1:0]   CNT_ZERO    = {CNT_BITWIDTH{1'b0}};
  localparam logic [CNT_BITWIDTH-1:0]   CNT_ONE     = CNT_BITWIDTH'(1);
  localparam logic [CNT_BITWIDTH-1:0]   CNT_LAST    = CNT_BITWIDTH'(ROW_NUM - 1);
  localparam logic [CNT_BITWIDTH-1:0]   CNT_CAPTURE = CNT_BITWIDTH'(ROW_NUM - 1 - ROW_INDEX);
  localparam logic [NSKIP_BITWIDTH-1:0] NSKIP_ONE   = NSKIP_BITWIDTH'(1);
  localparam logic [STAT_BITWIDTH-1:0]  SKIP_MAX    = {STAT_BITWIDTH{1'b1}};

  // Reduce a P+1-bit sum to P bits: clamp or wrap when the top two bits differ.
  function automatic logic [P_BITWIDTH-1:0] clamp_sum(input logic [P_BITWIDTH:0] sum);
    logic [P_BITWIDTH-1:0] res;
    if (sum[P_BITWIDTH] != sum[P_BITWIDTH-1]) begin
      if (SATURATE != 0) begin
        res = sum[P_BITWIDTH] ? {1'b1, {(P_BITWIDTH-1){1'b0}}} : {1'b0, {(P_BITWIDTH-1){1'b1}}};
      end else begin
        res = sum[P_BITWIDTH-1:0];
      end
    end else begin
      res = sum[P_BITWIDTH-1:0];
    end
    return res;
  endfunction

  logic                          w_swap_r, w_valid_r, a_valid_ff_r, p_valid_r, sat_flag_r;
  logic [W_BITWIDTH-1:0]         w_data_r, shadow_w_r, active_w_r, active_w_nxt_s;
  logic [LANES*A_BITWIDTH-1:0]   a_ff_r;
  logic [CNT_BITWIDTH-1:0]       w_fetch_cnt_r;
  logic                          shadow_valid_r, capture_s, add_valid_s;
  logic [A_BITWIDTH-1:0]         op_a_r [LANES];
  logic [W_BITWIDTH-1:0]         op_w_r [LANES];
  logic [LANES-1:0]              lane_zero_s, skip_lane_r, ovf_s;
  logic [M_BITWIDTH-1:0]         prod_s;
  logic [P_BITWIDTH:0]           prod_ext_s, sum_s;
  logic [LANES*P_BITWIDTH-1:0]   sum_sat_s, p_data_r;
  logic [NSKIP_BITWIDTH-1:0]     n_skip_s;
  logic [STAT_BITWIDTH:0]        skip_sum_s;
  logic [STAT_BITWIDTH-1:0]      skip_cnt_r, skip_nxt_s;

  // Capture detection and the weight active_w will hold after this edge.
  always_comb begin
    capture_s      = w_valid_in && (w_fetch_cnt_r == CNT_CAPTURE);
    active_w_nxt_s = active_w_r;
    if (w_swap_in && capture_s) begin
      active_w_nxt_s = w_data_in;   // captured beat bypasses the shadow register
    end else if (w_swap_in && shadow_valid_r) begin
      active_w_nxt_s = shadow_w_r;
    end else begin
      active_w_nxt_s = active_w_r;
    end
  end

  // Weight fetch counter, shadow and active weight registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_fetch_cnt_r  <= CNT_ZERO;
      shadow_w_r     <= {W_BITWIDTH{1'b0}};
      shadow_valid_r <= 1'b0;
      active_w_r     <= {W_BITWIDTH{1'b0}};
    end else begin
      active_w_r <= active_w_nxt_s;
      if (capture_s) begin
        shadow_w_r <= w_data_in;
      end
      if (w_swap_in) begin
        w_fetch_cnt_r  <= CNT_ZERO;
        shadow_valid_r <= 1'b0;
      end else if (w_valid_in) begin
        w_fetch_cnt_r <= (w_fetch_cnt_r == CNT_LAST) ? CNT_ZERO : (w_fetch_cnt_r + CNT_ONE);
        if (capture_s) begin
          shadow_valid_r <= 1'b1;
        end
      end
    end
  end

  // Registered pass-through of the weight and activation streams.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_swap_r     <= 1'b0;
      w_valid_r    <= 1'b0;
      w_data_r     <= {W_BITWIDTH{1'b0}};
      a_ff_r       <= {(LANES*A_BITWIDTH){1'b0}};
      a_valid_ff_r <= 1'b0;
    end else begin
      w_swap_r     <= w_swap_in;
      w_valid_r    <= w_valid_in;
      w_data_r     <= w_data_in;
      a_ff_r       <= a_data_in;
      a_valid_ff_r <= a_valid_in;
    end
  end

  // A lane is skipped when the activation entering a_ff or the next active weight is zero.
  always_comb begin
    lane_zero_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if ((a_data_in[i*A_BITWIDTH +: A_BITWIDTH] == {A_BITWIDTH{1'b0}}) ||
          (active_w_nxt_s == {W_BITWIDTH{1'b0}})) begin
        lane_zero_s[i] = 1'b1;
      end else begin
        lane_zero_s[i] = 1'b0;
      end
    end
  end

  // Multiplier operand registers: loaded alongside a_ff, frozen on skipped lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_lane_r <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        op_a_r[i] <= {A_BITWIDTH{1'b0}};
        op_w_r[i] <= {W_BITWIDTH{1'b0}};
      end
    end else begin
      skip_lane_r <= lane_zero_s;
      for (int i = 0; i < LANES; i++) begin
        if (!lane_zero_s[i]) begin
          op_a_r[i] <= a_data_in[i*A_BITWIDTH +: A_BITWIDTH];
          op_w_r[i] <= active_w_nxt_s;
        end
      end
    end
  end

  // Per-lane multiply, add with the partial sum above, overflow detect and clamp.
  always_comb begin
    prod_s     = {M_BITWIDTH{1'b0}};
    prod_ext_s = {(P_BITWIDTH+1){1'b0}};
    sum_s      = {(P_BITWIDTH+1){1'b0}};
    ovf_s      = {LANES{1'b0}};
    sum_sat_s  = {(LANES*P_BITWIDTH){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (skip_lane_r[i]) begin
        prod_s = {M_BITWIDTH{1'b0}};
      end else begin
        prod_s = $signed({{W_BITWIDTH{op_a_r[i][A_BITWIDTH-1]}}, op_a_r[i]}) *
                 $signed({{A_BITWIDTH{op_w_r[i][W_BITWIDTH-1]}}, op_w_r[i]});
      end
      prod_ext_s = {{(P_BITWIDTH+1-M_BITWIDTH){prod_s[M_BITWIDTH-1]}}, prod_s};
      if (ROW_INDEX != 0) begin
        sum_s = prod_ext_s + {p_data_in[i*P_BITWIDTH+P_BITWIDTH-1], p_data_in[i*P_BITWIDTH +: P_BITWIDTH]};
      end else begin
        sum_s = prod_ext_s;
      end
      ovf_s[i] = sum_s[P_BITWIDTH] ^ sum_s[P_BITWIDTH-1];
      sum_sat_s[i*P_BITWIDTH +: P_BITWIDTH] = clamp_sum(sum_s);
    end
  end

  // Result valid and saturating skip-count increment.
  always_comb begin
    add_valid_s = a_valid_ff_r && ((ROW_INDEX == 0) || p_valid_in);
    n_skip_s    = {NSKIP_BITWIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (a_valid_ff_r && skip_lane_r[i]) begin
        n_skip_s = n_skip_s + NSKIP_ONE;
      end else begin
        n_skip_s = n_skip_s;
      end
    end
    skip_sum_s = {1'b0, skip_cnt_r} + (STAT_BITWIDTH+1)'(n_skip_s);
    if (skip_sum_s > {1'b0, SKIP_MAX}) begin
      skip_nxt_s = SKIP_MAX;
    end else begin
      skip_nxt_s = skip_sum_s[STAT_BITWIDTH-1:0];
    end
  end

  // Partial-sum output register: data holds while add_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data_r  <= {(LANES*P_BITWIDTH){1'b0}};
      p_valid_r <= 1'b0;
    end else begin
      p_valid_r <= add_valid_s;
      if (add_valid_s) begin
        p_data_r <= sum_sat_s;
      end
    end
  end

  // Statistics: clear wins over same-cycle updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag_r <= 1'b0;
      skip_cnt_r <= {STAT_BITWIDTH{1'b0}};
    end else if (clr_stat_in) begin
      sat_flag_r <= 1'b0;
      skip_cnt_r <= {STAT_BITWIDTH{1'b0}};
    end else begin
      if (add_valid_s && (|ovf_s)) begin
        sat_flag_r <= 1'b1;
      end
      skip_cnt_r <= skip_nxt_s;
    end
  end

  assign w_swap_out  = w_swap_r;
  assign w_valid_out = w_valid_r;
  assign w_data_out  = w_data_r;
  assign a_data_out  = a_ff_r;
  assign a_valid_out = a_valid_ff_r;
  assign p_data_out  = p_data_r;
  assign p_valid_out = p_valid_r;
  assign sat_flag    = sat_flag_r;
  assign skip_cnt    = skip_cnt_r;

endmodule

// File: tb/tb_mac_pe_dbuf.sv
// Bench for mac_pe_dbuf: three instances (row 2 saturating, row 2 wrapping,
// row 0 saturating) share one stimulus and are compared every cycle against
// an arithmetic reference model, plus directed scenarios with literal results.
module tb_mac_pe_dbuf;
  localparam int A = 16, W = 8, P = 24, L = 2, RN = 4, SB = 4, NI = 3;
  localparam longint PMAX  = (longint'(1) << (P - 1)) - 1;
  localparam longint PMIN  = -(longint'(1) << (P - 1));
  localparam int     SKMAX = (1 << SB) - 1;

  function automatic int ri_of(int g);
    return (g == 2) ? 0 : 2;
  endfunction
  function automatic int sat_of(int g);
    return (g == 1) ? 0 : 1;
  endfunction

  logic clk, rst, w_swap_in, w_valid_in, a_valid_in, p_valid_in, clr_stat_in;
  logic [W-1:0]   w_data_in;
  logic [L*A-1:0] a_data_in;
  logic [L*P-1:0] p_data_in;

  logic           w_swap_out [NI];
  logic           w_valid_out [NI];
  logic [W-1:0]   w_data_out [NI];
  logic [L*A-1:0] a_data_out [NI];
  logic           a_valid_out [NI];
  logic [L*P-1:0] p_data_out [NI];
  logic           p_valid_out [NI];
  logic           sat_flag [NI];
  logic [SB-1:0]  skip_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_pe_dbuf #(
      .A_BITWIDTH(A), .W_BITWIDTH(W), .P_BITWIDTH(P), .LANES(L), .ROW_NUM(RN),
      .ROW_INDEX(ri_of(g)), .SATURATE(sat_of(g)), .STAT_BITWIDTH(SB)
    ) u_dut (
      .clk(clk), .rst(rst),
      .w_swap_in(w_swap_in), .w_swap_out(w_swap_out[g]),
      .w_data_in(w_data_in), .w_data_out(w_data_out[g]),
      .w_valid_in(w_valid_in), .w_valid_out(w_valid_out[g]),
      .a_data_in(a_data_in), .a_data_out(a_data_out[g]),
      .a_valid_in(a_valid_in), .a_valid_out(a_valid_out[g]),
      .p_data_in(p_data_in), .p_valid_in(p_valid_in),
      .p_data_out(p_data_out[g]), .p_valid_out(p_valid_out[g]),
      .clr_stat_in(clr_stat_in), .sat_flag(sat_flag[g]), .skip_cnt(skip_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_a(input logic [L*A-1:0] v, input int l);
    logic signed [A-1:0] x;
    x = v[l*A +: A];
    return int'(x);
  endfunction
  function automatic longint lane_p(input logic [L*P-1:0] v, input int l);
    logic signed [P-1:0] x;
    x = v[l*P +: P];
    return longint'(x);
  endfunction

  // ---------------- reference model ----------------
  int     m_beat [NI];
  int     m_shw  [NI];
  int     m_actw [NI];
  int     m_skip [NI];
  bit     m_shv  [NI];
  bit     m_pv   [NI];
  bit     m_sat  [NI];
  longint m_pout [NI][L];
  logic           e_w_swap, e_w_valid, e_a_valid;
  logic [W-1:0]   e_w_data;
  logic [L*A-1:0] e_a_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_beat[k] <= 0; m_shw[k] <= 0; m_actw[k] <= 0; m_skip[k] <= 0;
        m_shv[k] <= 1'b0; m_pv[k] <= 1'b0; m_sat[k] <= 1'b0;
        for (int l = 0; l < L; l++) m_pout[k][l] <= 0;
      end
      e_w_swap <= 1'b0; e_w_valid <= 1'b0; e_a_valid <= 1'b0;
      e_w_data <= '0; e_a_data <= '0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        bit addv, ovf, cap;
        int n, a, wv;
        longint s;
        logic signed [W-1:0] wsig;
        addv = e_a_valid && (ri_of(k) == 0 || p_valid_in);
        n = 0;
        ovf = 1'b0;
        for (int l = 0; l < L; l++) begin
          a = lane_a(e_a_data, l);
          if (e_a_valid && (a == 0 || m_actw[k] == 0)) n++;
          if (addv) begin
            s = longint'(a) * m_actw[k] + ((ri_of(k) != 0) ? lane_p(p_data_in, l) : 64'sd0);
            if (s > PMAX) begin
              ovf = 1'b1;
              s = (sat_of(k) != 0) ? PMAX : s - (longint'(1) << P);
            end else if (s < PMIN) begin
              ovf = 1'b1;
              s = (sat_of(k) != 0) ? PMIN : s + (longint'(1) << P);
            end
            m_pout[k][l] <= s;
          end
        end
        m_pv[k] <= addv;
        if (clr_stat_in) begin
          m_sat[k]  <= 1'b0;
          m_skip[k] <= 0;
        end else begin
          if (ovf) m_sat[k] <= 1'b1;
          m_skip[k] <= (m_skip[k] + n > SKMAX) ? SKMAX : m_skip[k] + n;
        end
        wsig = w_data_in;
        wv = int'(wsig);
        cap = w_valid_in && (m_beat[k] == RN - 1 - ri_of(k));
        if (w_swap_in) begin
          m_beat[k] <= 0;
          if (cap) begin
            m_actw[k] <= wv; m_shw[k] <= wv; m_shv[k] <= 1'b0;
          end else if (m_shv[k]) begin
            m_actw[k] <= m_shw[k]; m_shv[k] <= 1'b0;
          end
        end else begin
          if (cap) begin
            m_shw[k] <= wv; m_shv[k] <= 1'b1;
          end
          if (w_valid_in) m_beat[k] <= (m_beat[k] + 1) % RN;
        end
      end
      e_w_swap <= w_swap_in; e_w_valid <= w_valid_in; e_w_data <= w_data_in;
      e_a_valid <= a_valid_in; e_a_data <= a_data_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < NI; k++) begin
        for (int l = 0; l < L; l++)
          chk($sformatf("cyc i%0d p_lane%0d", k, l), lane_p(p_data_out[k], l), m_pout[k][l]);
        chk($sformatf("cyc i%0d p_valid", k), p_valid_out[k], m_pv[k]);
        chk($sformatf("cyc i%0d sat_flag", k), sat_flag[k], m_sat[k]);
        chk($sformatf("cyc i%0d skip_cnt", k), skip_cnt[k], m_skip[k]);
        chk($sformatf("cyc i%0d w_swap_out", k), w_swap_out[k], e_w_swap);
        chk($sformatf("cyc i%0d w_valid_out", k), w_valid_out[k], e_w_valid);
        chk($sformatf("cyc i%0d w_data_out", k), w_data_out[k], e_w_data);
        chk($sformatf("cyc i%0d a_data_out", k), a_data_out[k], e_a_data);
        chk($sformatf("cyc i%0d a_valid_out", k), a_valid_out[k], e_a_valid);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input int w, input bit sw, input bit v);
    w_data_in = W'(w); w_valid_in = v; w_swap_in = sw;
    tick();
    w_valid_in = 1'b0; w_swap_in = 1'b0; w_data_in = '0;
  endtask

  task automatic burst(input int w, input bit sw);
    for (int i = 0; i < RN; i++) send_w(w, 1'b0, 1'b1);
    if (sw) send_w(0, 1'b1, 1'b0);
  endtask

  task automatic do_mac(input int a0, input int a1, input longint p0, input longint p1, input bit pv);
    a_data_in = {A'(a1), A'(a0)}; a_valid_in = 1'b1;
    tick();
    a_valid_in = 1'b0; a_data_in = '0;
    p_data_in = {P'(p1), P'(p0)}; p_valid_in = pv;
    tick();
    p_valid_in = 1'b0; p_data_in = '0;
  endtask

  task automatic clr_pulse();
    clr_stat_in = 1'b1;
    tick();
    clr_stat_in = 1'b0;
  endtask

  function automatic longint pout(input int k, input int l);
    return lane_p(p_data_out[k], l);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; w_swap_in = 1'b0; w_valid_in = 1'b0; w_data_in = '0;
    a_valid_in = 1'b0; a_data_in = '0; p_valid_in = 1'b0; p_data_in = '0; clr_stat_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("reset p_data_out", p_data_out[k], 0);
      chk("reset p_valid_out", p_valid_out[k], 0);
      chk("reset skip_cnt", skip_cnt[k], 0);
      chk("reset sat_flag", sat_flag[k], 0);
    end

    // weight load and swap: row 2 captures beat 1, row 0 captures beat 3
    send_w(10, 1'b0, 1'b1); send_w(20, 1'b0, 1'b1); send_w(30, 1'b0, 1'b1); send_w(40, 1'b0, 1'b1);
    send_w(0, 1'b1, 1'b0);
    do_mac(3, 0, 0, 0, 1'b1);
    chk("load row2 p_out", pout(0, 0), 60);
    chk("load row2 wrap p_out", pout(1, 0), 60);
    chk("load row0 p_out", pout(2, 0), 120);

    // double buffer
    burst(5, 1'b1);
    burst(-7, 1'b0);
    do_mac(4, 0, 0, 0, 1'b1);
    chk("dbuf shadow not active", pout(0, 0), 20);
    send_w(0, 1'b1, 1'b0);
    do_mac(4, 0, 0, 0, 1'b1);
    chk("dbuf after swap", pout(0, 0), -28);
    send_w(0, 1'b1, 1'b0);
    do_mac(4, 0, 0, 0, 1'b1);
    chk("dbuf empty swap", pout(0, 0), -28);

    // swap coinciding with the capture beat
    send_w(1, 1'b0, 1'b1);
    send_w(9, 1'b1, 1'b1);
    do_mac(2, 0, 0, 0, 1'b1);
    chk("swapcap active", pout(0, 0), 18);
    send_w(0, 1'b1, 1'b0);
    do_mac(2, 0, 0, 0, 1'b1);
    chk("swapcap shadow empty", pout(0, 0), 18);
    send_w(11, 1'b0, 1'b1); send_w(12, 1'b0, 1'b1); send_w(0, 1'b1, 1'b0);
    do_mac(2, 0, 0, 0, 1'b1);
    chk("swapcap cnt restart", pout(0, 0), 24);

    // saturation versus wrap
    burst(1, 1'b1);
    clr_pulse();
    do_mac(100, 0, 64'sd8388598, 0, 1'b1);
    chk("sat clamp", pout(0, 0), 8388607);
    chk("sat flag", sat_flag[0], 1);
    chk("wrap value", pout(1, 0), -8388518);
    chk("wrap flag", sat_flag[1], 1);
    chk("row0 no p add", pout(2, 0), 100);
    chk("row0 no flag", sat_flag[2], 0);
    clr_pulse();
    chk("clr sat", sat_flag[0], 0);
    chk("clr wrap", sat_flag[1], 0);

    // zero skip and valid gating
    burst(3, 1'b1);
    clr_pulse();
    a_data_in = {16'sd5, 16'sd0}; a_valid_in = 1'b1;
    p_data_in = {24'sd100, 24'sd7}; p_valid_in = 1'b1;
    repeat (4) tick();
    a_valid_in = 1'b0; a_data_in = '0;
    tick();
    p_valid_in = 1'b0; p_data_in = '0;
    chk("skip cnt 4", skip_cnt[0], 4);
    chk("skip lane1", pout(0, 1), 115);
    chk("skip lane0", pout(0, 0), 7);
    chk("skip row0 lane1", pout(2, 1), 15);
    a_data_in = {16'sd6, 16'sd0}; a_valid_in = 1'b1;
    tick();
    a_valid_in = 1'b0; a_data_in = '0;
    tick();
    chk("gate p_valid", p_valid_out[0], 0);
    chk("gate hold", pout(0, 1), 115);
    chk("gate skip", skip_cnt[0], 5);
    chk("gate row0 lane1", pout(2, 1), 18);

    // asynchronous reset mid-burst
    send_w(50, 1'b0, 1'b1); send_w(60, 1'b0, 1'b1);
    a_data_in = {16'sd1, 16'sd2}; a_valid_in = 1'b1; w_valid_in = 1'b1; w_data_in = 8'd33;
    tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("arst p_data", p_data_out[k], 0);
      chk("arst p_valid", p_valid_out[k], 0);
      chk("arst skip", skip_cnt[k], 0);
      chk("arst a_data", a_data_out[k], 0);
      chk("arst a_valid", a_valid_out[k], 0);
      chk("arst w_data", w_data_out[k], 0);
      chk("arst w_valid", w_valid_out[k], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    a_valid_in = 1'b0; a_data_in = '0; w_valid_in = 1'b0; w_data_in = '0;
    send_w(70, 1'b0, 1'b1); send_w(80, 1'b0, 1'b1); send_w(90, 1'b0, 1'b1); send_w(100, 1'b0, 1'b1);
    send_w(0, 1'b1, 1'b0);
    do_mac(1, 0, 0, 0, 1'b1);
    chk("arst restart row2", pout(0, 0), 80);
    chk("arst restart row0", pout(2, 0), 100);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      w_valid_in  = 1'($urandom_range(0, 1));
      w_data_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      w_swap_in   = ($urandom_range(0, 11) == 0);
      a_valid_in  = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < L; l++) begin
        a_data_in[l*A +: A] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        p_data_in[l*P +: P] = 24'($urandom);
      end
      p_valid_in  = ($urandom_range(0, 9) < 8);
      clr_stat_in = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; w_valid_in = 1'b0; w_swap_in = 1'b0; a_valid_in = 1'b0;
    p_valid_in = 1'b0; clr_stat_in = 1'b0;
    repeat (3) tick();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
